seq_and_comb: RTL and testbench
===============================

Name: seq_and_comb

Overview:
Minimal mixed sequential/combinational primitive for the shared RTL library. It has two independent paths. The sequential path is a resettable D-register chain that delays data_in onto q_out. The combinational path is a 2:1 multiplexer that drives y_out from a_in or b_in under sel_in. It is used as a leaf cell in datapaths that need one registered bit and one steered bit together.

Parameters:
WIDTH, 1, bit width of data_in/q_out and a_in/b_in/y_out
STAGES, 1, number of register stages between data_in and q_out; legal range 1..16

Ports:
clk  input  1  rising-edge clock for the register chain
rst  input  1  asynchronous, active-high reset; clears the register chain
data_in  input  WIDTH  sequential-path data input
q_out  output  WIDTH  registered output; data_in delayed by STAGES clock edges
a_in  input  WIDTH  mux input selected when sel_in=0
b_in  input  WIDTH  mux input selected when sel_in=1
sel_in  input  1  mux select
y_out  output  WIDTH  mux output

Behaviour:
- Interface: one clock (clk), all state on its rising edge. Reset rst is asynchronous and active-high.
- Reset:
  - rst=1 immediately forces every chain stage to 0, so q_out=0 without waiting for a clock edge.
  - Reset holds while rst=1.
  - After rst falls, the first capture happens on the next rising clk edge.
- Sequential path:
  - stage[0] <= data_in on each rising edge. stage[k] <= stage[k-1] for k=1..STAGES-1.
  - q_out = stage[STAGES-1].
  - Latency is exactly STAGES rising edges. With STAGES=1, q_out updates at the edge that samples data_in.
- Setup/hold: data_in changing coincident with a rising edge is undefined in gate-level terms. In RTL simulation, the value before the edge is the one captured (nonblocking semantics).
- Reset mid-operation: any data in flight is discarded. q_out returns to 0 and refills with fresh samples STAGES edges after reset release.
- Combinational path:
  - y_out = sel_in ? b_in : a_in, bitwise across WIDTH, with zero latency.
  - It does not depend on clk or rst; y_out follows its inputs even while rst=1.
- Independence: the two paths share no logic. Mux activity never affects q_out, and the register chain never affects y_out.
- Parameter check: STAGES outside 1..16 must fail elaboration, via a generate-time error block.

Optional Feature:
Macro MUX_OUT_REG_EN.
- Defined:
  - y_out is registered: y_out <= (sel_in ? b_in : a_in) on each rising clk edge.
  - rst clears this register to 0 asynchronously.
  - Mux latency becomes 1 cycle.
- Not defined:
  - y_out is purely combinational as described above.
  - No extra flop is inferred.
- q_out behaviour is identical in both builds.

Test Plan:
1. Reset: rst=1 with data_in=1 and clock running -> q_out=0 at once and stays 0. Release rst at t=12 -> q_out=1 after the edge at t=15 (WIDTH=1, STAGES=1, 10 ns clock).
2. Register capture: data_in=0, then 1 at t=10, then 0 at t=20 -> q_out rises at the t=15 edge and falls at the t=25 edge. q_out never changes between edges.
3. Mux select: (sel,a,b)=(0,0,1) -> y=0; (1,1,0) -> y=0; (0,1,0) -> y=1; (1,0,1) -> y=1. Each result appears in the same timestep with no clock dependency.
4. Mux under reset: hold rst=1 and apply sel=1, b_in=1 -> y_out=1 without MUX_OUT_REG_EN, and y_out=0 with MUX_OUT_REG_EN.
5. Depth and width: WIDTH=8, STAGES=3, drive 0xA5, 0x3C, 0xFF on consecutive edges -> q_out shows the same sequence starting 3 edges later. Assert rst mid-stream -> q_out=0x00 immediately.
6. MUX_OUT_REG_EN build: change sel_in from 0 to 1 between edges with a=0x00 and b=0xFF -> y_out holds its value until the next rising edge, then becomes 0xFF.

Source files
------------

// File: rtl/seq_and_comb.sv
// Leaf cell: resettable STAGES-deep register chain (data_in -> q_out) plus an independent 2:1 mux (a_in/b_in -> y_out).
// Latency: q_out lags data_in by STAGES rising edges; y_out is zero-latency (one edge when MUX_OUT_REG_EN is defined).
// Backpressure: none; both paths accept a new value every cycle and never stall.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      asynchronous active-high reset; clears the chain (and the mux output flop when present)
//   data_in  sequential-path input, WIDTH bits
//   q_out    data_in delayed by STAGES edges
//   a_in     mux input selected when sel_in=0
//   b_in     mux input selected when sel_in=1
//   sel_in   mux select
//   y_out    mux output
//
// Optional build macro: MUX_OUT_REG_EN -- registers y_out on clk, cleared by rst.
// Parameters: WIDTH (default 1), STAGES (default 1, legal 1..16).

module seq_and_comb #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sel_in,
    output logic [WIDTH-1:0] y_out
);

    // Reject illegal chain depths at elaboration rather than building
    // a chain with a negative or oversized index range.
    generate
        if (STAGES < 1 || STAGES > 16) begin : g_stages_check
            $error("seq_and_comb: STAGES=%0d is outside the legal range 1..16", STAGES);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequential path: register chain
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= data_in;
            // Empty loop when STAGES=1: the single stage is the output.
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q_out = stage[STAGES-1];

    // ------------------------------------------------------------------
    // Combinational path: 2:1 mux, shares nothing with the chain
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mux_dat;

    assign mux_dat = sel_in ? b_in : a_in;

`ifdef MUX_OUT_REG_EN
    // Registered variant: one edge of latency, cleared with the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out <= '0;
        end else begin
            y_out <= mux_dat;
        end
    end
`else
    // Pure combinational variant: follows inputs even while rst=1.
    assign y_out = mux_dat;
`endif

endmodule

// File: tb/tb_seq_and_comb.sv
// Directed self-checking bench for seq_and_comb: a WIDTH=1/STAGES=1 instance and a WIDTH=8/STAGES=3 instance.
// Latency: checks are sampled 1 ns after rising edges or mid-cycle, never on the edge itself.
// Backpressure: not applicable; stimulus is applied every cycle as needed.

module tb_seq_and_comb;

    logic       clk;
    logic       rst;

    logic       data1;
    logic       q1;
    logic       a1;
    logic       b1;
    logic       sel1;
    logic       y1;

    logic [7:0] data8;
    logic [7:0] q8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       sel8;
    logic [7:0] y8;

    int n_checks = 0;
    int n_fail   = 0;

    seq_and_comb #(
        .WIDTH  (1),
        .STAGES (1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data1),
        .q_out   (q1),
        .a_in    (a1),
        .b_in    (b1),
        .sel_in  (sel1),
        .y_out   (y1)
    );

    seq_and_comb #(
        .WIDTH  (8),
        .STAGES (3)
    ) dut8 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data8),
        .q_out   (q8),
        .a_in    (a8),
        .b_in    (b8),
        .sel_in  (sel8),
        .y_out   (y8)
    );

    // 10 ns clock, rising edges at t=5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard bound on total run time.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded 50000 ns without finishing");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst   = 1'b0;
        data1 = 1'b1;
        data8 = 8'hA5;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0;
        #1 rst = 1'b1;                       // t=1, no clock edge yet
        #1;                                  // t=2
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL reset_async_q1: got %b expected 0", q1); end
        n_checks++;
        if (q8 !== 8'h00) begin n_fail++; $display("FAIL reset_async_q8: got %h expected 00", q8); end
        @(posedge clk); #2;                  // t=7, edge at 5 with rst held
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL reset_hold_q1: got %b expected 0", q1); end
        #5 rst = 1'b0;                       // t=12
        #1;                                  // t=13
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL reset_release_no_edge: got %b expected 0", q1); end
        @(posedge clk); #1;                  // t=16, after edge at 15
        n_checks++;
        if (q1 !== 1'b1) begin n_fail++; $display("FAIL reset_first_capture_q1: got %b expected 1", q1); end
        n_checks++;
        if (q8 !== 8'h00) begin n_fail++; $display("FAIL reset_first_capture_q8: got %h expected 00", q8); end
    endtask

    task automatic test_capture();
        data1 = 1'b0;                        // t=16
        @(posedge clk); #1;                  // t=26
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL capture_zero: got %b expected 0", q1); end
        data1 = 1'b1;
        #4;                                  // t=30, between edges
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL capture_no_change_between_edges: got %b expected 0", q1); end
        @(posedge clk); #1;                  // t=36
        n_checks++;
        if (q1 !== 1'b1) begin n_fail++; $display("FAIL capture_rise: got %b expected 1", q1); end
        data1 = 1'b0;
        #3;
        n_checks++;
        if (q1 !== 1'b1) begin n_fail++; $display("FAIL capture_hold_high: got %b expected 1", q1); end
        @(posedge clk); #1;
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL capture_fall: got %b expected 0", q1); end
    endtask

    task automatic test_mux_select();
        logic [3:0] tbl [4];                 // {sel, a, b, expected y}
        logic [7:0] exp8;
        tbl[0] = 4'b0010;
        tbl[1] = 4'b1100;
        tbl[2] = 4'b0101;
        tbl[3] = 4'b1011;
        a8 = 8'h5A;
        b8 = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            sel1 = tbl[i][3];
            a1   = tbl[i][2];
            b1   = tbl[i][1];
            sel8 = tbl[i][3];
            exp8 = tbl[i][3] ? 8'hC3 : 8'h5A;
`ifdef MUX_OUT_REG_EN
            @(posedge clk); #1;
`else
            #1;
`endif
            n_checks++;
            if (y1 !== tbl[i][0]) begin
                n_fail++;
                $display("FAIL mux_select_y1[%0d]: got %b expected %b", i, y1, tbl[i][0]);
            end
            n_checks++;
            if (y8 !== exp8) begin
                n_fail++;
                $display("FAIL mux_select_y8[%0d]: got %h expected %h", i, y8, exp8);
            end
        end
        // Mux activity must leave the chain alone (data1 held at 0).
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL mux_independent_q1: got %b expected 0", q1); end
    endtask

    task automatic test_mux_under_reset();
        logic       exp1;
        logic [7:0] exp8;
`ifdef MUX_OUT_REG_EN
        exp1 = 1'b0;
        exp8 = 8'h00;
`else
        exp1 = 1'b1;
        exp8 = 8'hF0;
`endif
        #2 rst = 1'b1;                       // mid-cycle
        a1 = 1'b0; b1 = 1'b1; sel1 = 1'b1;
        a8 = 8'h0F; b8 = 8'hF0; sel8 = 1'b1;
        #1;
        n_checks++;
        if (y1 !== exp1) begin n_fail++; $display("FAIL mux_under_reset_y1: got %b expected %b", y1, exp1); end
        n_checks++;
        if (y8 !== exp8) begin n_fail++; $display("FAIL mux_under_reset_y8: got %h expected %h", y8, exp8); end
        @(posedge clk); #1;
        n_checks++;
        if (y1 !== exp1) begin n_fail++; $display("FAIL mux_under_reset_after_edge: got %b expected %b", y1, exp1); end
        n_checks++;
        if (q1 !== 1'b0) begin n_fail++; $display("FAIL mux_under_reset_q1: got %b expected 0", q1); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_depth_width();
        logic [7:0] vals [6];
        logic [7:0] exp8;
        vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF;
        vals[3] = 8'h00; vals[4] = 8'h00; vals[5] = 8'h00;
        @(negedge clk);
        rst   = 1'b1;
        data8 = 8'h00;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data8 = vals[i];
            @(posedge clk); #1;
            exp8 = (i >= 2) ? vals[i-2] : 8'h00;
            n_checks++;
            if (q8 !== exp8) begin
                n_fail++;
                $display("FAIL depth_seq_q8[edge %0d]: got %h expected %h", i, q8, exp8);
            end
        end
        // Fill with 11,22,33 then reset mid-stream.
        data8 = 8'h11; @(posedge clk); #1;
        data8 = 8'h22; @(posedge clk); #1;
        data8 = 8'h33; @(posedge clk); #1;
        n_checks++;
        if (q8 !== 8'h11) begin n_fail++; $display("FAIL depth_prefill_q8: got %h expected 11", q8); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (q8 !== 8'h00) begin n_fail++; $display("FAIL depth_midstream_reset_q8: got %h expected 00", q8); end
        @(negedge clk);
        rst   = 1'b0;
        data8 = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp8 = (i == 2) ? 8'h77 : 8'h00;
            n_checks++;
            if (q8 !== exp8) begin
                n_fail++;
                $display("FAIL depth_refill_q8[edge %0d]: got %h expected %h", i, q8, exp8);
            end
        end
    endtask

    task automatic test_mux_timing();
        logic [7:0] exp_mid;
`ifdef MUX_OUT_REG_EN
        exp_mid = 8'h00;
`else
        exp_mid = 8'hFF;
`endif
        a8 = 8'h00; b8 = 8'hFF; sel8 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (y8 !== 8'h00) begin n_fail++; $display("FAIL mux_timing_before: got %h expected 00", y8); end
        #2 sel8 = 1'b1;
        #1;
        n_checks++;
        if (y8 !== exp_mid) begin n_fail++; $display("FAIL mux_timing_between_edges: got %h expected %h", y8, exp_mid); end
        @(posedge clk); #1;
        n_checks++;
        if (y8 !== 8'hFF) begin n_fail++; $display("FAIL mux_timing_after_edge: got %h expected FF", y8); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_mux_select();
        test_mux_under_reset();
        test_depth_width();
        test_mux_timing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
